// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and memory-busy freeze,
// with saturating stall and flush event counters.
module pipeline_hazard_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_uses_rs1,
    input  logic        ID_uses_rs2,
    input  logic [4:0]  EX_rd,
    input  logic        EX_mem_read,
    input  logic        Branch_Taken,
    input  logic        Mem_Busy,
    output logic        STALL,
    output logic        DUMP,
    output logic        PC_Write,
    output logic        ID_EX_Bubble,
    output logic        Pipe_Freeze,
    output logic [15:0] Stall_Cycles,
    output logic [15:0] Flush_Count
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t state;
    state_t state_next;
    logic   load_use;
    logic   flush_inc;

    // Load in Execute whose destination is a live source of the Decode instruction
    always_comb begin
        load_use = EX_mem_read && (EX_rd != REG_W'(0)) &&
                   ((ID_uses_rs1 && (ID_rs1 == EX_rd)) ||
                    (ID_uses_rs2 && (ID_rs2 == EX_rd)));
    end

    // Control outputs are same-cycle; priority: reset, busy, branch, flush, load-use
    always_comb begin
        STALL        = 1'b0;
        DUMP         = 1'b0;
        PC_Write     = 1'b1;
        ID_EX_Bubble = 1'b0;
        Pipe_Freeze  = 1'b0;
        flush_inc    = 1'b0;
        state_next   = state;

        if (reset) begin
            PC_Write     = 1'b0;
            DUMP         = 1'b1;
            ID_EX_Bubble = 1'b1;
            state_next   = RUN;
        end else if (Mem_Busy) begin
            STALL       = 1'b1;
            PC_Write    = 1'b0;
            Pipe_Freeze = 1'b1;
        end else if (Branch_Taken) begin
            DUMP         = 1'b1;
            ID_EX_Bubble = 1'b1;
            flush_inc    = 1'b1;
            state_next   = FLUSH;
        end else if (state == FLUSH) begin
            // Second squash cycle covers the instruction-memory read latency
            DUMP       = 1'b1;
            state_next = RUN;
        end else if (load_use) begin
            STALL        = 1'b1;
            PC_Write     = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            Stall_Cycles <= '0;
            Flush_Count  <= '0;
        end else begin
            state <= state_next;
            if (STALL && (Stall_Cycles != CNT_MAX))
                Stall_Cycles <= Stall_Cycles + CNT_W'(1);
            if (flush_inc && (Flush_Count != CNT_MAX))
                Flush_Count <= Flush_Count + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 clock  input  1  pipeline clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ID_rs1  input  5  rs1 index of the instruction in Decode.
REQ-005 ID_rs2  input  5  rs2 index of the instruction in Decode.
REQ-006 ID_uses_rs1  input  1  Decode instruction reads rs1.
REQ-007 ID_uses_rs2  input  1  Decode instruction reads rs2.
REQ-008 EX_rd  input  5  destination index of the instruction in Execute.
REQ-009 EX_mem_read  input  1  Execute instruction is a load.
REQ-010 Branch_Taken  input  1  Execute resolved a taken branch or jump this cycle.
REQ-011 Mem_Busy  input  1  data memory not ready; the whole pipeline must hold.
REQ-012 STALL  output  1  hold the IF/ID register (instruction and PC recirculate).
REQ-013 DUMP  output  1  load NOP 0x00000013 into the IF/ID register.
REQ-014 PC_Write  output  1  PC register update enable.
REQ-015 ID_EX_Bubble  output  1  load a NOP into the ID/EX register.
REQ-016 Pipe_Freeze  output  1  hold the ID/EX, EX/MEM and MEM/WB registers.
REQ-017 Stall_Cycles  output  16  count of cycles with STALL=1.
REQ-018 Flush_Count  output  16  count of accepted taken branches.

Function
REQ-019 State register: RUN, FLUSH; all control outputs SHALL be combinational from state and current inputs (same-cycle effect); the state and both counters SHALL be registered.
REQ-020 Load-use hazard LU = EX_mem_read & (EX_rd!=0) & ((ID_uses_rs1 & ID_rs1==EX_rd) | (ID_uses_rs2 & ID_rs2==EX_rd)).
REQ-021 Priority, highest first: reset, Mem_Busy, Branch_Taken, FLUSH state, LU, none.
REQ-022 Mem_Busy=1: STALL=1, PC_Write=0, Pipe_Freeze=1, DUMP=0, ID_EX_Bubble=0; state SHALL hold; Branch_Taken and LU SHALL be ignored (they re-present once Mem_Busy drops).
REQ-023 Branch_Taken=1 (no Mem_Busy), any state: DUMP=1, ID_EX_Bubble=1, PC_Write=1, STALL=0; next state FLUSH; Flush_Count SHALL increment.
REQ-024 FLUSH (no Mem_Busy, no Branch_Taken): DUMP=1, PC_Write=1, STALL=0, ID_EX_Bubble=0 (covers the one-cycle instruction-memory read latency); next state RUN; LU SHALL be ignored in this cycle.
REQ-025 RUN with LU: STALL=1, PC_Write=0, ID_EX_Bubble=1, DUMP=0; exactly one stall cycle per load (the bubble clears LU).
REQ-026 RUN with none: STALL=0, DUMP=0, PC_Write=1, ID_EX_Bubble=0, Pipe_Freeze=0.
REQ-027 DUMP and STALL SHALL never both be 1.
REQ-028 Stall_Cycles SHALL increment on every non-reset cycle with STALL=1; both counters SHALL saturate at 0xFFFF (no wrap).
REQ-029 A branch arriving while in FLUSH SHALL restart FLUSH (one further FLUSH cycle after it) and count once.

Reset
REQ-030 While reset=1: state<=RUN, Stall_Cycles<=0, Flush_Count<=0; outputs STALL=0, PC_Write=0, DUMP=1, ID_EX_Bubble=1, Pipe_Freeze=0.
REQ-031 Reset asserted mid-FLUSH or mid-Mem_Busy SHALL take effect at the next edge, discarding pending flush; the first cycle after release SHALL be RUN.

Verification
REQ-032 Load-use: EX_mem_read=1, EX_rd=5, ID_uses_rs1=1, ID_rs1=5 for one cycle -> STALL=1, PC_Write=0, ID_EX_Bubble=1 that cycle; Stall_Cycles 0->1.
REQ-033 x0 guard: same as REQ-032 with EX_rd=0, ID_rs1=0 -> STALL=0, PC_Write=1, counter unchanged.
REQ-034 Branch: Branch_Taken=1 one cycle -> DUMP=1, ID_EX_Bubble=1; next cycle DUMP=1, ID_EX_Bubble=0; third cycle DUMP=0; Flush_Count=1.
REQ-035 Busy overrides: Mem_Busy=1 for 3 cycles with Branch_Taken=1 and LU=1 -> STALL=1, Pipe_Freeze=1, DUMP=0 for 3 cycles, Flush_Count=0, Stall_Cycles=3; on release branch is taken (DUMP=1).
REQ-036 Saturation: 70000 consecutive stall cycles -> Stall_Cycles=0xFFFF, no wrap.
REQ-037 Reset mid-FLUSH: Branch_Taken, then reset=1 next cycle -> DUMP=1, counters 0; after release state RUN, DUMP=0.
